// File: rtl/sram_1w1r_ctrl_if.sv
// Client-side bundle for sram_1w1r_ctrl: two write requesters, read request,
// read response and the init status flag.
interface sram_1w1r_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WMASKS = 4
);
  logic                  wa_valid;
  logic                  wa_ready;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_data;
  logic [NUM_WMASKS-1:0] wa_mask;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [NUM_WMASKS-1:0] wb_mask;

  logic                  rq_valid;
  logic                  rq_ready;
  logic [ADDR_WIDTH-1:0] rq_addr;

  logic                  rs_valid;
  logic                  rs_ready;
  logic [DATA_WIDTH-1:0] rs_data;

  logic                  init_done;

  modport master (
    output wa_valid, wa_addr, wa_data, wa_mask,
    output wb_valid, wb_addr, wb_data, wb_mask,
    output rq_valid, rq_addr, rs_ready,
    input  wa_ready, wb_ready, rq_ready, rs_valid, rs_data, init_done
  );

  modport slave (
    input  wa_valid, wa_addr, wa_data, wa_mask,
    input  wb_valid, wb_addr, wb_data, wb_mask,
    input  rq_valid, rq_addr, rs_ready,
    output wa_ready, wb_ready, rq_ready, rs_valid, rs_data, init_done
  );
endinterface

// File: rtl/sram_1w1r_ctrl.sv
// Front-end for a 1W1R masked SRAM macro: post-reset clear, round-robin write
// arbitration, and credit-limited reads into a 2-entry response queue.
module sram_1w1r_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_1w1r_ctrl_if.slave       bus,
  output logic                  csb0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  prio_b;
  logic                  inflight;
  logic                  head;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] queue [2];

  logic                  run;
  logic                  grant_a;
  logic                  grant_b;
  logic                  wr_fire;
  logic                  wr_active;
  logic                  hazard;
  logic                  rd_fire;
  logic                  pop;
  logic [1:0]            occupancy;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_WMASKS-1:0] wr_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && init_cnt == {ADDR_WIDTH{1'b1}}) state_next = RUN;
  end

  // Outputs are gated by rst so the macro sees idle pins while reset is held.
  always_comb begin
    run       = (state == RUN) && !rst;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    wr_addr   = bus.wa_addr;
    wr_data   = bus.wa_data;
    wr_mask   = bus.wa_mask;
    wr_fire   = 1'b0;
    wr_active = 1'b0;
    hazard    = 1'b0;
    rd_fire   = 1'b0;
    occupancy = count + {1'b0, inflight};
    csb0      = 1'b1;
    addr0     = '0;
    din0      = '0;
    wmask0    = '0;
    csb1      = 1'b1;
    addr1     = '0;

    if (run) begin
      grant_b = bus.wb_valid && (!bus.wa_valid || prio_b);
      grant_a = bus.wa_valid && !grant_b;
      if (grant_b) begin
        wr_addr = bus.wb_addr;
        wr_data = bus.wb_data;
        wr_mask = bus.wb_mask;
      end
      wr_fire   = grant_a || grant_b;
      wr_active = wr_fire && (wr_mask != '0);
      hazard    = wr_active && (wr_addr == bus.rq_addr);
      rd_fire   = bus.rq_valid && (occupancy < 2'd2) && !hazard;
    end

    if (!rst && state == INIT) begin
      csb0   = 1'b0;
      addr0  = init_cnt;
      wmask0 = '1;
    end else if (wr_fire) begin
      csb0   = !wr_active;
      addr0  = wr_addr;
      din0   = wr_data;
      wmask0 = wr_mask;
    end

    if (rd_fire) begin
      csb1  = 1'b0;
      addr1 = bus.rq_addr;
    end

    bus.wa_ready  = grant_a;
    bus.wb_ready  = grant_b;
    bus.rq_ready  = run && (occupancy < 2'd2) && !hazard;
    bus.rs_valid  = !rst && (count != 2'd0);
    bus.rs_data   = queue[head];
    bus.init_done = run;
    pop           = bus.rs_valid && bus.rs_ready;
  end

  // A read accepted last cycle lands its macro data in the queue now.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b   <= 1'b0;
      inflight <= 1'b0;
      head     <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (wr_fire) prio_b <= grant_a;
      inflight <= rd_fire;
      if (pop) head <= ~head;
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && inflight) queue[head ^ count[0]] <= dout1;
  end

endmodule

// File: tb/tb_sram_1w1r_ctrl.sv
// Directed self-checking bench for sram_1w1r_ctrl with a behavioural masked
// 1W1R macro that fills itself with ones during reset.
module tb_sram_1w1r_ctrl;
  localparam int AW = 5;
  localparam int DW = 128;
  localparam int NM = 4;
  localparam int LW = DW / NM;

  localparam logic [DW-1:0] DA  = 128'hDA0A_0001_DA0A_0002_DA0A_0003_DA0A_0004;
  localparam logic [DW-1:0] DB  = 128'hDB0B_0011_DB0B_0012_DB0B_0013_DB0B_0014;
  localparam logic [DW-1:0] D7  = 128'h7777_0000_1234_5678_9ABC_DEF0_0F0F_7007;
  localparam logic [DW-1:0] DX  = 128'hFEED_FACE_CAFE_BEEF_0BAD_F00D_DEAD_C0DE;
  localparam logic [DW-1:0] A5  = {16{8'hA5}};

  logic          clk = 1'b0;
  logic          rst;
  logic          csb0;
  logic          csb1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout1;
  logic [NM-1:0] wmask0;
  logic [DW-1:0] mem [32];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sram_1w1r_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM)) bus ();

  sram_1w1r_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .csb0   (csb0),
    .addr0  (addr0),
    .din0   (din0),
    .wmask0 (wmask0),
    .csb1   (csb1),
    .addr1  (addr1),
    .dout1  (dout1)
  );

  // Macro model: reads return pre-write contents on a shared edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '1;
    end else if (!csb0) begin
      for (int l = 0; l < NM; l++)
        if (wmask0[l]) mem[addr0][l*LW +: LW] <= din0[l*LW +: LW];
    end
    if (!csb1) dout1 <= mem[addr1];
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    compared++;
    mismatched++;
    $error("[TB] FAIL %s: observed no handshake expected handshake within 20 cycles", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    bus.wa_valid = 1'b0; bus.wa_addr = '0; bus.wa_data = '0; bus.wa_mask = '0;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.wb_mask = '0;
    bus.rq_valid = 1'b0; bus.rq_addr = '0; bus.rs_ready = 1'b0;
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NM-1:0] m);
    int n = 0;
    bus.wa_valid = 1'b1; bus.wa_addr = a; bus.wa_data = d; bus.wa_mask = m;
    #1;
    while (!bus.wa_ready && n < 20) begin step(); n++; end
    if (n == 20) timeoutFail("write_handshake");
    step();
    bus.wa_valid = 1'b0;
    #1;
  endtask

  task automatic doRead(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n = 0;
    d = '0;
    bus.rq_valid = 1'b1; bus.rq_addr = a;
    #1;
    while (!bus.rq_ready && n < 20) begin step(); n++; end
    if (n == 20) timeoutFail("read_accept");
    step();
    bus.rq_valid = 1'b0;
    #1;
    n = 0;
    while (!bus.rs_valid && n < 20) begin step(); n++; end
    if (n == 20) timeoutFail("read_response");
    d = bus.rs_data;
    bus.rs_ready = 1'b1;
    step();
    bus.rs_ready = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    applyStimulus();
    rst = 1'b1;
    step();
    step();

    // Reset values while rst is held
    checkOutput("rst_csb0", csb0, 1);
    checkOutput("rst_csb1", csb1, 1);
    checkOutput("rst_wmask0", wmask0, 0);
    checkOutput("rst_addr0", addr0, 0);
    checkOutput("rst_din0", din0, 0);
    checkOutput("rst_addr1", addr1, 0);
    checkOutput("rst_rs_valid", bus.rs_valid, 0);
    checkOutput("rst_init_done", bus.init_done, 0);
    checkOutput("rst_rq_ready", bus.rq_ready, 0);

    // Init sweep with requests pending: nothing may be granted
    bus.wa_valid = 1'b1;
    bus.wb_valid = 1'b1;
    bus.rq_valid = 1'b1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      checkOutput("init_csb0", csb0, 0);
      checkOutput("init_addr0", addr0, i);
      checkOutput("init_din0", din0, 0);
      checkOutput("init_wmask0", wmask0, 4'hF);
      checkOutput("init_wa_ready", bus.wa_ready, 0);
      checkOutput("init_rq_ready", bus.rq_ready, 0);
      checkOutput("init_csb1", csb1, 1);
      checkOutput("init_done_low", bus.init_done, 0);
      step();
    end
    checkOutput("init_done_high", bus.init_done, 1);
    checkOutput("first_wa_ready", bus.wa_ready, 1);
    checkOutput("first_rq_ready", bus.rq_ready, 1);
    applyStimulus();
    #1;

    for (int i = 0; i < 32; i++) begin
      doRead(i[AW-1:0], d);
      checkOutput("clear_readback", d, 0);
    end

    // Round-robin with both requesters valid
    bus.wa_valid = 1'b1; bus.wa_addr = 5'd10; bus.wa_data = DA; bus.wa_mask = 4'hF;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd11; bus.wb_data = DB; bus.wb_mask = 4'hF;
    #1;
    for (int k = 0; k < 6; k++) begin
      checkOutput("arb_wa_ready", bus.wa_ready, (k % 2 == 0) ? 1 : 0);
      checkOutput("arb_wb_ready", bus.wb_ready, (k % 2 == 0) ? 0 : 1);
      checkOutput("arb_addr0", addr0, (k % 2 == 0) ? 10 : 11);
      checkOutput("arb_csb0", csb0, 0);
      step();
    end
    applyStimulus();
    #1;
    doRead(5'd10, d);
    checkOutput("arb_read_a", d, DA);
    doRead(5'd11, d);
    checkOutput("arb_read_b", d, DB);

    // Single-lane write keeps the other lanes
    doWrite(5'd5, '1, 4'hF);
    doWrite(5'd5, '0, 4'b0001);
    doRead(5'd5, d);
    checkOutput("lane_mask", d, {{96{1'b1}}, 32'h0});

    // Mask-zero write completes the handshake without touching the macro
    doWrite(5'd7, D7, 4'hF);
    bus.wa_valid = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = DX; bus.wa_mask = 4'h0;
    #1;
    checkOutput("mask0_wa_ready", bus.wa_ready, 1);
    checkOutput("mask0_csb0", csb0, 1);
    step();
    bus.wa_valid = 1'b0;
    #1;
    doRead(5'd7, d);
    checkOutput("mask0_readback", d, D7);

    // Same-address read stalls one cycle behind the write
    bus.wa_valid = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = A5; bus.wa_mask = 4'hF;
    bus.rq_valid = 1'b1; bus.rq_addr = 5'd3;
    #1;
    checkOutput("hazard_rq_ready", bus.rq_ready, 0);
    checkOutput("hazard_wa_ready", bus.wa_ready, 1);
    checkOutput("hazard_csb1", csb1, 1);
    step();
    bus.wa_valid = 1'b0;
    #1;
    checkOutput("hazard_retry_ready", bus.rq_ready, 1);
    checkOutput("hazard_retry_csb1", csb1, 0);
    step();
    bus.rq_valid = 1'b0;
    #1;
    checkOutput("hazard_latency", bus.rs_valid, 0);
    step();
    checkOutput("hazard_rs_valid", bus.rs_valid, 1);
    checkOutput("hazard_rs_data", bus.rs_data, A5);
    bus.rs_ready = 1'b1;
    step();
    bus.rs_ready = 1'b0;
    #1;

    // Backpressure: only two reads outstanding with rs_ready low
    bus.rq_valid = 1'b1; bus.rq_addr = 5'd10;
    #1;
    checkOutput("bp_accept0", bus.rq_ready, 1);
    step();
    bus.rq_addr = 5'd11;
    #1;
    checkOutput("bp_accept1", bus.rq_ready, 1);
    step();
    bus.rq_addr = 5'd12;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_stall", bus.rq_ready, 0);
      step();
    end
    bus.rq_valid = 1'b0;
    bus.rs_ready = 1'b1;
    #1;
    checkOutput("bp_drain0_valid", bus.rs_valid, 1);
    checkOutput("bp_drain0_data", bus.rs_data, DA);
    step();
    checkOutput("bp_drain1_valid", bus.rs_valid, 1);
    checkOutput("bp_drain1_data", bus.rs_data, DB);
    step();
    checkOutput("bp_empty", bus.rs_valid, 0);
    bus.rs_ready = 1'b0;
    #1;
    doRead(5'd12, d);
    checkOutput("bp_read12", d, 0);
    doRead(5'd13, d);
    checkOutput("bp_read13", d, 0);

    // Reset with one response queued and one read in flight
    bus.rq_valid = 1'b1; bus.rq_addr = 5'd10;
    #1;
    step();
    bus.rq_addr = 5'd11;
    #1;
    step();
    bus.rq_valid = 1'b0;
    #1;
    checkOutput("mid_pre_rs_valid", bus.rs_valid, 1);
    rst = 1'b1;
    step();
    checkOutput("mid_rs_valid", bus.rs_valid, 0);
    checkOutput("mid_init_done", bus.init_done, 0);
    checkOutput("mid_csb1", csb1, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_addr0", addr0, 0);
    checkOutput("mid_csb0", csb0, 0);
    for (int i = 0; i < 32; i++) step();
    checkOutput("mid_init_done_high", bus.init_done, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("mid_no_stale", bus.rs_valid, 0);
      step();
    end
    doRead(5'd10, d);
    checkOutput("mid_reclear", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
